// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the pipeline registers behind it.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // Instruction word injected when a pipeline slot is flushed.
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register between fetch and decode: load, hold or flush, plus a valid bit.
// Flush clears valid and replaces the instruction with NOP; the PC fields keep their
// last value since nothing downstream looks at them while valid is low.
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             flush,
    input  logic [WIDTH-1:0] d_instr,
    input  logic [WIDTH-1:0] d_pc,
    input  logic [WIDTH-1:0] d_pc4,
    output logic             valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc4
);

    // Priority: reset, then flush, then load; otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
            pc4   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= WIDTH'(NOP);
        end else if (load) begin
            valid <= 1'b1;
            instr <= d_instr;
            pc    <= d_pc;
            pc4   <= d_pc4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM, one-entry skid buffer and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             ifid_valid,
    output logic [WIDTH-1:0] ifid_instr,
    output logic [WIDTH-1:0] ifid_pc,
    output logic [WIDTH-1:0] ifid_pc4
);

    fetch_state_e     state, state_nxt;
    logic [WIDTH-1:0] pc, pc_nxt;
    logic [WIDTH-1:0] skid_instr, skid_pc;
    logic             skid_load, skid_clear;
    logic             ld, fl;
    logic [WIDTH-1:0] ld_instr, ld_pc;

    // The fetch address is always the PC; a request is only issued in FETCH.
    always_comb begin
        imem_req  = (state == FETCH);
        imem_addr = pc;
    end

    // Next-state, PC update and IF/ID / skid control; redirect beats everything.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        ld         = 1'b0;
        fl         = 1'b0;
        ld_instr   = imem_rdata;
        ld_pc      = pc;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (redirect) begin
            // Low bits dropped so the target is always word aligned.
            pc_nxt     = redirect_pc & ~WIDTH'(3);
            fl         = 1'b1;
            skid_clear = 1'b1;
            state_nxt  = FETCH;
        end else begin
            case (state)
                IDLE: state_nxt = FETCH;
                FETCH: begin
                    if (imem_ready && !stall) begin
                        ld     = 1'b1;
                        pc_nxt = pc + WIDTH'(4);
                    end else if (imem_ready && stall) begin
                        // Word arrived but decode is busy: park it, stop requesting.
                        skid_load = 1'b1;
                        state_nxt = HOLD;
                    end else if (!stall) begin
                        fl = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ld        = 1'b1;
                        ld_instr  = skid_instr;
                        ld_pc     = skid_pc;
                        pc_nxt    = pc + WIDTH'(4);
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, PC and skid buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (skid_clear) begin
                skid_instr <= '0;
                skid_pc    <= '0;
            end else if (skid_load) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
            end
        end
    end

    ifid_reg #(.WIDTH(WIDTH)) u_ifid (
        .clk     (clk),
        .reset   (reset),
        .load    (ld),
        .flush   (fl),
        .d_instr (ld_instr),
        .d_pc    (ld_pc),
        .d_pc4   (ld_pc + WIDTH'(4)),
        .valid   (ifid_valid),
        .instr   (ifid_instr),
        .pc      (ifid_pc),
        .pc4     (ifid_pc4)
    );

endmodule
